// File: rtl/cv_dac_ramp.sv
// Slew-limited CV-loop DAC sequencer: ramps the DAC code toward a firmware target
// in tick-paced steps and runs VBUS discharge after a downward ramp.
module cv_dac_ramp #(
   parameter int DW  = 10,
   parameter int TW  = 8,
   parameter int DTO = 200
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_tick,
   input  logic [DW-1:0] i_tgt,
   input  logic          i_tgt_wr,
   input  logic [3:0]    i_step,
   input  logic [TW-1:0] i_intv,
   input  logic          i_abort,
   input  logic          i_vo_hi,
   output logic [DW-1:0] o_dac,
   output logic          o_dischg,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_dis_to,
   output logic [2:0]    o_state
);

   // state  | meaning
   // IDLE   | no ramp in progress, code held
   // UP     | stepping code upward toward target
   // DN     | stepping code downward toward target
   // DSCHG  | discharge enabled until VBUS falls or timeout
   // SETTLE | waiting one step period before reporting done
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UP     = 3'd1,
      DN     = 3'd2,
      DSCHG  = 3'd3,
      SETTLE = 3'd4
   } state_t;

   localparam logic [TW-1:0] DTO_M1 = TW'(DTO - 1);

   state_t        state;
   logic [DW-1:0] tgt;
   logic [TW-1:0] cnt;
   logic [TW-1:0] dcnt;

   logic                 step_ev;
   logic [DW:0]          step_eff;
   logic [DW:0]          sum;
   logic signed [DW+1:0] diff;
   logic                 up_hit;
   logic                 dn_hit;

   always_comb begin
      step_ev  = i_tick && (cnt == '0);
      step_eff = (i_step == 4'd0) ? (DW+1)'(1) : (DW+1)'(i_step);
      sum      = {1'b0, o_dac} + step_eff;
      // one guard bit beyond the sum so a large step below zero stays negative
      diff     = $signed({2'b00, o_dac}) - $signed({1'b0, step_eff});
      up_hit   = (sum >= {1'b0, tgt});
      dn_hit   = (diff <= $signed({2'b00, tgt}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         o_dac    <= '0;
         tgt      <= '0;
         cnt      <= '0;
         dcnt     <= '0;
         o_dischg <= 1'b0;
         o_done   <= 1'b0;
         o_dis_to <= 1'b0;
      end else begin
         o_done <= 1'b0;

         if (i_tgt_wr && !(i_abort && state != IDLE))
            cnt <= i_intv;
         else if (i_tick)
            cnt <= (cnt == '0) ? i_intv : cnt - 1'b1;

         if (i_abort && state != IDLE) begin
            state    <= IDLE;
            o_dischg <= 1'b0;
         end else if (i_tgt_wr) begin
            tgt      <= i_tgt;
            o_dis_to <= 1'b0;
            o_dischg <= 1'b0;
            if (i_tgt > o_dac)      state <= UP;
            else if (i_tgt < o_dac) state <= DN;
            else                    state <= SETTLE;
         end else begin
            case (state)
               UP: if (step_ev) begin
                  if (up_hit) begin
                     o_dac <= tgt;
                     state <= SETTLE;
                  end else begin
                     o_dac <= sum[DW-1:0];
                  end
               end
               DN: if (step_ev) begin
                  if (dn_hit) begin
                     o_dac    <= tgt;
                     state    <= DSCHG;
                     dcnt     <= '0;
                     o_dischg <= 1'b1;
                  end else begin
                     o_dac <= diff[DW-1:0];
                  end
               end
               DSCHG: begin
                  if (!i_vo_hi) begin
                     state    <= SETTLE;
                     o_dischg <= 1'b0;
                  end else if (i_tick) begin
                     if (dcnt == DTO_M1) begin
                        o_dis_to <= 1'b1;
                        state    <= SETTLE;
                        o_dischg <= 1'b0;
                     end
                     dcnt <= dcnt + 1'b1;
                  end
               end
               SETTLE: if (step_ev) begin
                  state  <= IDLE;
                  o_done <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_busy  = (state != IDLE);
   assign o_state = state;

endmodule

// File: tb/tb_cv_dac_ramp.sv
// Directed bench for cv_dac_ramp: ramps, discharge, timeout, saturation, abort, reset.
module tb_cv_dac_ramp;

   localparam int DW = 10;
   localparam int TW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_tick;
   logic [DW-1:0] i_tgt;
   logic          i_tgt_wr;
   logic [3:0]    i_step;
   logic [TW-1:0] i_intv;
   logic          i_abort;
   logic          i_vo_hi;
   logic [DW-1:0] o_dac;
   logic          o_dischg;
   logic          o_busy;
   logic          o_done;
   logic          o_dis_to;
   logic [2:0]    o_state;

   int n_cmp = 0;
   int n_err = 0;

   cv_dac_ramp #(.DW(DW), .TW(TW), .DTO(200)) dut (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_tgt(i_tgt), .i_tgt_wr(i_tgt_wr),
      .i_step(i_step), .i_intv(i_intv), .i_abort(i_abort), .i_vo_hi(i_vo_hi),
      .o_dac(o_dac), .o_dischg(o_dischg), .o_busy(o_busy), .o_done(o_done),
      .o_dis_to(o_dis_to), .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk) i_tick = 1'b1;
      @(negedge clk) i_tick = 1'b0;
   endtask

   task automatic wr(input int v);
      @(negedge clk) begin i_tgt = DW'(v); i_tgt_wr = 1'b1; end
      @(negedge clk) i_tgt_wr = 1'b0;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; i_tick = 0; i_tgt = '0; i_tgt_wr = 0; i_step = 4'd5;
      i_intv = '0; i_abort = 0; i_vo_hi = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_cycle();
      chk("rst_state", o_state, 0);
      chk("rst_dac", o_dac, 0);
      chk("rst_dischg", o_dischg, 0);
      chk("rst_done", o_done, 0);
      chk("rst_dis_to", o_dis_to, 0);
      chk("rst_busy", o_busy, 0);

      // up-ramp 0 -> 23 in steps of 5, one step per tick
      wr(23);
      chk("up_state", o_state, 1);
      chk("up_busy", o_busy, 1);
      tick(); chk("up_dac5", o_dac, 5);
      tick(); chk("up_dac10", o_dac, 10);
      tick(); chk("up_dac15", o_dac, 15);
      tick(); chk("up_dac20", o_dac, 20);
      chk("up_dischg", o_dischg, 0);
      tick(); chk("up_dac23", o_dac, 23);
      chk("up_settle", o_state, 4);
      tick(); chk("up_done", o_done, 1);
      chk("up_idle", o_state, 0);
      idle_cycle(); chk("up_done_1clk", o_done, 0);

      // down-ramp 23 -> 3 every 2 ticks, then discharge
      i_step = 4'd8; i_intv = 8'd1; i_vo_hi = 1'b1;
      wr(3);
      chk("dn_state", o_state, 2);
      tick(); chk("dn_hold", o_dac, 23);
      tick(); chk("dn_dac15", o_dac, 15);
      tick(); tick(); chk("dn_dac7", o_dac, 7);
      tick(); tick(); chk("dn_dac3", o_dac, 3);
      chk("dn_dschg", o_state, 3);
      chk("dn_dischg_on", o_dischg, 1);
      repeat (10) tick();
      chk("dn_still_dschg", o_state, 3);
      i_vo_hi = 1'b0;
      idle_cycle();
      chk("dn_to_settle", o_state, 4);
      chk("dn_dischg_off", o_dischg, 0);
      tick(); chk("dn_settle_wait", o_state, 4);
      tick(); chk("dn_done", o_done, 1);
      chk("dn_dis_to", o_dis_to, 0);

      // discharge timeout: 3 -> 0 (signed clamp), VBUS stays high
      i_intv = 8'd0; i_vo_hi = 1'b1;
      wr(0);
      tick(); chk("to_dac0", o_dac, 0);
      chk("to_dschg", o_state, 3);
      repeat (199) tick();
      chk("to_199_state", o_state, 3);
      chk("to_199_flag", o_dis_to, 0);
      tick();
      chk("to_200_state", o_state, 4);
      chk("to_200_flag", o_dis_to, 1);
      chk("to_dischg_off", o_dischg, 0);
      tick(); chk("to_done", o_done, 1);
      chk("to_flag_sticky", o_dis_to, 1);
      wr(0);
      chk("to_flag_clr", o_dis_to, 0);
      chk("to_eq_settle", o_state, 4);
      tick(); chk("to_eq_done", o_done, 1);

      // saturation at the top of the code range
      i_step = 4'd15; i_vo_hi = 1'b0;
      wr(1020);
      repeat (68) tick();
      chk("sat_dac1020", o_dac, 1020);
      tick(); chk("sat_done1", o_done, 1);
      wr(1023);
      tick(); chk("sat_dac1023", o_dac, 1023);
      chk("sat_settle", o_state, 4);
      tick();

      // step of 0 behaves as 1
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      i_step = 4'd0;
      wr(2);
      tick(); chk("step0_dac1", o_dac, 1);
      tick(); chk("step0_dac2", o_dac, 2);
      tick(); chk("step0_done", o_done, 1);

      // abort wins over simultaneous retarget
      i_step = 4'd2;
      wr(100);
      repeat (19) tick();
      chk("ab_dac40", o_dac, 40);
      chk("ab_up", o_state, 1);
      @(negedge clk) begin i_abort = 1'b1; i_tgt_wr = 1'b1; i_tgt = 10'd50; end
      @(negedge clk) begin i_abort = 1'b0; i_tgt_wr = 1'b0; end
      chk("ab_idle", o_state, 0);
      chk("ab_dac_hold", o_dac, 40);
      chk("ab_no_done", o_done, 0);
      tick(); chk("ab_stays", o_dac, 40);
      wr(40);
      chk("ab_eq_settle", o_state, 4);
      tick(); chk("ab_eq_done", o_done, 1);

      // reset during discharge
      i_step = 4'd8; i_vo_hi = 1'b1;
      wr(0);
      repeat (5) tick();
      chk("rd_dschg", o_state, 3);
      chk("rd_dischg", o_dischg, 1);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("rd_dischg0", o_dischg, 0);
      chk("rd_dac0", o_dac, 0);
      chk("rd_idle", o_state, 0);
      chk("rd_done0", o_done, 0);
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cv_dac_ramp.md
# cv_dac_ramp

Slew-limited sequencer for the CV-loop DAC code in the power path. It accepts a target DAC code from firmware (SFR side), steps the DAC toward it in programmable increments at a programmable tick interval, and runs VBUS discharge after a downward ramp. It signals completion with a one-cycle done pulse. It sits between the SFR bank and the analog DAC/discharge controls in the core, clocked from the MCU clock domain.

## Interface
- DW, default 10, DAC code width
- TW, default 8, step-interval counter width
- DTO, default 200, discharge timeout in ticks (must be < 2^TW)

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- i_tick  in  1  1 us prescaler strobe, one clk wide
- i_tgt  in  DW  target DAC code, sampled on i_tgt_wr
- i_tgt_wr  in  1  target load strobe
- i_step  in  4  code increment per step; 0 is treated as 1
- i_intv  in  TW  ticks between steps, minus 1
- i_abort  in  1  abort the ramp and hold the present code
- i_vo_hi  in  1  comparator: VBUS above the level implied by o_dac
- o_dac  out  DW  DAC code to analog
- o_dischg  out  1  VBUS discharge enable
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle completion pulse
- o_dis_to  out  1  sticky discharge-timeout flag
- o_state  out  3  current state, for debug/SFR readback

## Operation
- States (encoding): IDLE=0, UP=1, DN=2, DSCHG=3, SETTLE=4.
- Reset values: state IDLE, o_dac 0, target 0, interval counter 0, o_dischg 0, o_done 0, o_dis_to 0.
- i_tgt_wr (any state) latches i_tgt, clears o_dis_to, and loads the interval counter with i_intv. Next state is chosen by comparison:
  - target > o_dac: UP
  - target < o_dac: DN
  - target == o_dac: SETTLE
- A retarget mid-ramp takes effect immediately. o_dac is not reset.
- Step event: i_tick high and counter == 0. The counter reloads i_intv on each step event and decrements on every other tick. Step period is therefore (i_intv+1) ticks.
- UP: on a step event, o_dac = min(o_dac + step, target).
  - Computed in DW+1 bits, so there is no wrap past 2^DW-1.
  - When o_dac reaches target, go to SETTLE and reload the counter.
- DN: on a step event, o_dac = max(o_dac − step, target).
  - Computed signed, so there is no underflow below 0.
  - When o_dac reaches target, go to DSCHG and clear the discharge counter.
- DSCHG: o_dischg = 1.
  - If i_vo_hi is 0, go to SETTLE.
  - Otherwise the discharge counter counts ticks. If it reaches DTO, set o_dis_to and go to SETTLE.
- SETTLE: wait for one step event, then go to IDLE with o_done = 1 for that single cycle.
- i_abort in a non-IDLE state: go to IDLE next cycle, hold o_dac, drop o_dischg, no o_done. i_abort in IDLE has no effect.
- Priority: i_abort > i_tgt_wr > step/discharge progress.
- i_step and i_intv are sampled live at every step or reload. Changes mid-ramp apply to the next step.

## Timing
- i_tgt_wr at cycle N: o_state and o_busy change at N+1.
- Step event at cycle N: o_dac updates at N+1. All outputs are registered.
- The first step occurs (i_intv+1) ticks after i_tgt_wr.
- o_dischg asserts the cycle the state becomes DSCHG. It deasserts the cycle the state leaves DSCHG.
- o_done is high for exactly 1 clk, coincident with o_state returning to IDLE.
- rst asserted mid-ramp: all outputs take their reset values at the next edge, including o_dac = 0.

## Test plan
- Up-ramp: rst; i_step=5, i_intv=0, tgt=23. Require o_dac 0→5→10→15→20→23 on consecutive ticks, then SETTLE, then o_done after one more tick. o_dischg stays 0 throughout.
- Down-ramp with discharge: from 23, i_step=8, i_intv=1, tgt=3. Require o_dac 23→15→7→3 every 2 ticks, then DSCHG with o_dischg=1. Drop i_vo_hi after 10 ticks; require SETTLE next cycle and o_done.
- Discharge timeout: DTO=200, keep i_vo_hi=1. Require o_dis_to=1 and exit to SETTLE exactly 200 ticks after entering DSCHG. A following i_tgt_wr clears o_dis_to.
- Saturation: i_step=15 with tgt=1023 from 1020 gives 1023, not a wrap. i_step=0 with tgt=2 from 0 gives 1, then 2.
- Abort and retarget: during UP at o_dac=40, assert i_abort and i_tgt_wr together. Require IDLE, o_dac=40, no o_done. Then write tgt=40: require SETTLE, then o_done.
- Reset mid-DSCHG: assert rst. Require o_dischg=0, o_dac=0, state IDLE, and o_done=0 at the next edge.
